// File: rtl/heartbeat_tx.sv
// Heartbeat transmitter: toggles hb_out every HALF_PERIOD cycles in RUN and freezes it when the kick watchdog expires.
// Latency: all outputs are registered. The first toggle comes STARTUP_DELAY edges after en is first sampled high.
// Backpressure: none. Inputs are sampled every cycle, and stop or en=0 takes effect at the edge where it is sampled.
module heartbeat_tx #(
    parameter int unsigned HALF_PERIOD   = 250000,
    parameter int unsigned KICK_TIMEOUT  = 2000000,
    parameter int unsigned STARTUP_DELAY = 16,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned KICK_W        = 22
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        kick,
    input  logic        stop,
    output logic        hb_out,
    output logic        running,
    output logic        timeout_flag,
    output logic [15:0] beat_cnt
);

    // Terminal values of each counter. Each counter wraps or transitions on its terminal value, so it never overflows.
    localparam logic [CNT_W-1:0]  HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]  SD_LAST  = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [KICK_W-1:0] KT_LAST  = KICK_W'(KICK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [KICK_W-1:0] KICK_ONE = KICK_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STARTUP = 2'd1,
        RUN     = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   per_cnt;
    logic [CNT_W-1:0]   per_nxt;
    logic [CNT_W-1:0]   st_cnt;
    logic [CNT_W-1:0]   st_nxt;
    logic [KICK_W-1:0]  kick_cnt;
    logic [KICK_W-1:0]  kick_nxt;
    logic               hb_nxt;
    logic               tflag_nxt;
    logic [15:0]        beat_nxt;
    logic               halt;

    // stop and a dropped enable share one path back to IDLE. Both rank above the watchdog and the toggle.
    assign halt = stop | ~en;

    // State and output registers, with a synchronous active-low reset that clears everything.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= IDLE;
            per_cnt      <= '0;
            st_cnt       <= '0;
            kick_cnt     <= '0;
            hb_out       <= 1'b0;
            running      <= 1'b0;
            timeout_flag <= 1'b0;
            beat_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            per_cnt      <= per_nxt;
            st_cnt       <= st_nxt;
            kick_cnt     <= kick_nxt;
            hb_out       <= hb_nxt;
            running      <= (state_nxt == RUN);
            timeout_flag <= tflag_nxt;
            beat_cnt     <= beat_nxt;
        end
    end

    // Next-state and next-value logic. Every register holds unless the current state says otherwise.
    always_comb begin
        state_nxt = state;
        per_nxt   = per_cnt;
        st_nxt    = st_cnt;
        kick_nxt  = kick_cnt;
        hb_nxt    = hb_out;
        tflag_nxt = timeout_flag;
        beat_nxt  = beat_cnt;

        unique case (state)
            IDLE: begin
                if (!halt) begin
                    state_nxt = STARTUP;
                    st_nxt    = '0;
                    beat_nxt  = '0;
                    tflag_nxt = 1'b0;
                end
            end

            STARTUP: begin
                kick_nxt = '0;
                if (halt) begin
                    state_nxt = IDLE;
                end else if (st_cnt == SD_LAST) begin
                    // The first beat goes out on the same edge that enters RUN.
                    state_nxt = RUN;
                    hb_nxt    = ~hb_out;
                    beat_nxt  = beat_cnt + 16'd1;
                    per_nxt   = '0;
                end else begin
                    st_nxt = st_cnt + CNT_ONE;
                end
            end

            RUN: begin
                if (halt) begin
                    state_nxt = IDLE;
                end else if (!kick && (kick_cnt == KT_LAST)) begin
                    // A kick on the expiry edge rescues the link, so only a missing kick faults.
                    state_nxt = FAULT;
                    tflag_nxt = 1'b1;
                end else begin
                    if (per_cnt == HP_LAST) begin
                        hb_nxt   = ~hb_out;
                        beat_nxt = beat_cnt + 16'd1;
                        per_nxt  = '0;
                    end else begin
                        per_nxt = per_cnt + CNT_ONE;
                    end
                    kick_nxt = kick ? '0 : (kick_cnt + KICK_ONE);
                end
            end

            FAULT: begin
                // The line stays frozen so the far-end monitor times out.
                if (halt) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_heartbeat_tx.sv
// Self-checking bench for heartbeat_tx with HALF_PERIOD=4, KICK_TIMEOUT=10 and STARTUP_DELAY=3.
// Expected toggles (edge, level, beat count) are queued as each scenario starts, and a monitor pops one per observed toggle.
// Level outputs are checked directly at the edges each scenario calls out.
module tb_heartbeat_tx;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        kick;
    logic        stop;
    logic        hb_out;
    logic        running;
    logic        timeout_flag;
    logic [15:0] beat_cnt;

    heartbeat_tx #(
        .HALF_PERIOD   (4),
        .KICK_TIMEOUT  (10),
        .STARTUP_DELAY (3),
        .CNT_W         (24),
        .KICK_W        (22)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .kick         (kick),
        .stop         (stop),
        .hb_out       (hb_out),
        .running      (running),
        .timeout_flag (timeout_flag),
        .beat_cnt     (beat_cnt)
    );

    typedef struct {
        int          at_edge;
        logic        hb;
        logic [15:0] beat;
    } tgl_t;

    tgl_t exp_q[$];
    int   n_chk;
    int   n_pass;
    int   edge_no;
    int   base;
    logic hb_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_no - base);
        end
    endtask

    task automatic push_tgl(input int e, input logic h, input int b);
        tgl_t t;
        t.at_edge = e;
        t.hb      = h;
        t.beat    = 16'(b);
        exp_q.push_back(t);
    endtask

    // Matches every hb_out change against the head of the expected-toggle queue.
    task automatic mon();
        tgl_t t;
        if (!nrst) begin
            hb_prev = hb_out;
            return;
        end
        if (hb_out !== hb_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_toggle", 32'(hb_out), 32'(hb_prev));
            end else begin
                t = exp_q.pop_front();
                chk("toggle_edge", edge_no - base, t.at_edge);
                chk("toggle_level", 32'(hb_out), 32'(t.hb));
                chk("toggle_beat", 32'(beat_cnt), 32'(t.beat));
            end
        end else if (exp_q.size() != 0 && exp_q[0].at_edge == edge_no - base) begin
            t = exp_q.pop_front();
            chk("missed_toggle", 32'(hb_out), 32'(t.hb));
        end
        hb_prev = hb_out;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
        mon();
    endtask

    task automatic do_reset();
        exp_q.delete();
        nrst = 1'b0;
        en   = 1'b0;
        kick = 1'b0;
        stop = 1'b0;
        step();
        step();
        nrst    = 1'b1;
        hb_prev = hb_out;
    endtask

    task automatic finish_scn(input string tag);
        en   = 1'b0;
        kick = 1'b0;
        stop = 1'b0;
        step();
        chk({tag, "_running_off"}, 32'(running), 32'd0);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        edge_no = 0;
        base    = 0;
        hb_prev = 1'b0;
        nrst    = 1'b0;
        en      = 1'b0;
        kick    = 1'b0;
        stop    = 1'b0;

        // Reset state, then a long idle stretch with en low.
        do_reset();
        chk("rst_hb", 32'(hb_out), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        chk("rst_beat", 32'(beat_cnt), 32'd0);
        base = edge_no + 1;
        for (int e = 0; e < 20; e++) begin
            en = 1'b0;
            step();
            chk("idle_outputs", 32'({hb_out, running, timeout_flag, beat_cnt}), 32'd0);
        end

        // Normal run with a kick every 5 cycles.
        do_reset();
        push_tgl(3, 1'b1, 1);
        push_tgl(7, 1'b0, 2);
        push_tgl(11, 1'b1, 3);
        push_tgl(15, 1'b0, 4);
        base = edge_no + 1;
        for (int e = 0; e <= 17; e++) begin
            en   = 1'b1;
            kick = ((e % 5) == 4);
            step();
            if (e == 2)  chk("norm_running_e2", 32'(running), 32'd0);
            if (e == 3)  chk("norm_running_e3", 32'(running), 32'd1);
            if (e == 17) chk("norm_tflag", 32'(timeout_flag), 32'd0);
        end
        finish_scn("norm");

        // No kicks: FAULT at edge 13, then re-enable clears the flag.
        do_reset();
        push_tgl(3, 1'b1, 1);
        push_tgl(7, 1'b0, 2);
        push_tgl(11, 1'b1, 3);
        push_tgl(21, 1'b0, 1);
        base = edge_no + 1;
        for (int e = 0; e <= 22; e++) begin
            en   = (e != 17);
            kick = 1'b0;
            step();
            if (e == 12) chk("nokick_tflag_e12", 32'(timeout_flag), 32'd0);
            if (e == 12) chk("nokick_running_e12", 32'(running), 32'd1);
            if (e == 13) chk("nokick_tflag_e13", 32'(timeout_flag), 32'd1);
            if (e == 13) chk("nokick_running_e13", 32'(running), 32'd0);
            if (e == 16) chk("nokick_hb_frozen", 32'(hb_out), 32'd1);
            if (e == 16) chk("nokick_beat_frozen", 32'(beat_cnt), 32'd3);
            if (e == 17) chk("nokick_tflag_sticky", 32'(timeout_flag), 32'd1);
            if (e == 18) chk("nokick_tflag_clear", 32'(timeout_flag), 32'd0);
            if (e == 18) chk("nokick_beat_clear", 32'(beat_cnt), 32'd0);
        end
        finish_scn("nokick");

        // A single kick at edge 12 pushes the timeout out to edge 22.
        do_reset();
        push_tgl(3, 1'b1, 1);
        push_tgl(7, 1'b0, 2);
        push_tgl(11, 1'b1, 3);
        push_tgl(15, 1'b0, 4);
        push_tgl(19, 1'b1, 5);
        base = edge_no + 1;
        for (int e = 0; e <= 24; e++) begin
            en   = 1'b1;
            kick = (e == 12);
            step();
            if (e == 13) chk("kick12_tflag_e13", 32'(timeout_flag), 32'd0);
            if (e == 21) chk("kick12_running_e21", 32'(running), 32'd1);
            if (e == 22) chk("kick12_tflag_e22", 32'(timeout_flag), 32'd1);
            if (e == 22) chk("kick12_running_e22", 32'(running), 32'd0);
            if (e == 24) chk("kick12_beat_frozen", 32'(beat_cnt), 32'd5);
        end
        finish_scn("kick12");

        // stop on a toggle edge suppresses the toggle. Releasing stop restarts the full startup.
        do_reset();
        push_tgl(3, 1'b1, 1);
        push_tgl(11, 1'b0, 1);
        base = edge_no + 1;
        for (int e = 0; e <= 12; e++) begin
            en   = 1'b1;
            kick = 1'b0;
            stop = (e == 7);
            step();
            if (e == 7)  chk("stop_hb", 32'(hb_out), 32'd1);
            if (e == 7)  chk("stop_beat", 32'(beat_cnt), 32'd1);
            if (e == 7)  chk("stop_running", 32'(running), 32'd0);
            if (e == 8)  chk("stop_beat_restart", 32'(beat_cnt), 32'd0);
            if (e == 10) chk("stop_running_e10", 32'(running), 32'd0);
            if (e == 11) chk("stop_running_e11", 32'(running), 32'd1);
        end
        finish_scn("stop");

        // Reset mid-RUN while hb_out is high, then re-enable straight out of reset.
        do_reset();
        push_tgl(3, 1'b1, 1);
        push_tgl(9, 1'b1, 1);
        base = edge_no + 1;
        for (int e = 0; e <= 10; e++) begin
            nrst = (e != 5);
            en   = 1'b1;
            kick = 1'b0;
            step();
            if (e == 4)  chk("midrst_hb_before", 32'(hb_out), 32'd1);
            if (e == 5)  chk("midrst_outputs", 32'({hb_out, running, timeout_flag, beat_cnt}), 32'd0);
            if (e == 8)  chk("midrst_running_e8", 32'(running), 32'd0);
            if (e == 9)  chk("midrst_running_e9", 32'(running), 32'd1);
        end
        nrst = 1'b1;
        finish_scn("midrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
